// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the output-stationary systolic matrix-multiply array.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_OUT
  } state_t;

  // Index width for a counter over n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Low bit of lane `lane` in a flat vector of `w`-bit lanes.
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One MAC cell: forwards a to the right and b downward through a register each,
// and accumulates ext(a)*ext(b) modulo 2^ACC_W, sign- or zero-extended per sgn.
module systolic_pe #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 48
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              sgn,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);

  logic signed [DATA_W:0]     a_x;
  logic signed [DATA_W:0]     b_x;
  logic signed [2*DATA_W+1:0] prod;

  // One extra bit per operand lets a single signed multiplier serve both modes.
  assign a_x  = {sgn & a_in[DATA_W-1], a_in};
  assign b_x  = {sgn & b_in[DATA_W-1], b_in};
  assign prod = a_x * b_x;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= clr ? '0 : acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/systolic_mm_array.sv
// Output-stationary ROWS x COLS systolic array: streams A columns / B rows in,
// skews them across the PE grid, then drains C one row per valid/ready beat.
module systolic_mm_array
  import systolic_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 48,
  localparam int IDX_W = idx_w(ROWS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_signed,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [ROWS*DATA_W-1:0] a_vec,
  input  logic [COLS*DATA_W-1:0] b_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COLS*ACC_W-1:0]  out_row,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   busy
);

  localparam int CNT_W = idx_w(ROWS + COLS);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ROWS + COLS - 2);
  localparam logic [IDX_W-1:0] ROW_LAST   = IDX_W'(ROWS - 1);

  state_t             state;
  logic [CNT_W-1:0]   drain_cnt;
  logic [IDX_W-1:0]   row;
  logic               sgn;
  logic               accept;
  logic               clr;

  logic [DATA_W-1:0]  a_h [ROWS][COLS];
  logic [DATA_W-1:0]  b_v [ROWS][COLS];
  logic [ACC_W-1:0]   acc [ROWS][COLS];
  logic [DATA_W-1:0]  a_unused [ROWS];
  logic [DATA_W-1:0]  b_unused [COLS];

  // in_ready is a pure state decode so no path exists from out_ready.
  assign in_ready = rst_n && (state == ST_IDLE || state == ST_LOAD);
  assign accept   = in_valid && in_ready;
  assign clr      = accept && (state == ST_IDLE);
  assign out_idx  = row;

  // Lane i of A is delayed i cycles beyond the input register; B lanes likewise.
  for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
    logic [DATA_W-1:0] sr [i+1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) sr[s] <= '0;
      end else begin
        sr[0] <= accept ? a_vec[lane_lo(i, DATA_W) +: DATA_W] : '0;
        for (int s = 1; s <= i; s++) sr[s] <= sr[s-1];
      end
    end
    assign a_h[i][0] = sr[i];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b_skew
    logic [DATA_W-1:0] sr [j+1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int s = 0; s <= j; s++) sr[s] <= '0;
      end else begin
        sr[0] <= accept ? b_vec[lane_lo(j, DATA_W) +: DATA_W] : '0;
        for (int s = 1; s <= j; s++) sr[s] <= sr[s-1];
      end
    end
    assign b_v[0][j] = sr[j];
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      logic [DATA_W-1:0] a_nxt;
      logic [DATA_W-1:0] b_nxt;

      systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .sgn   (sgn),
        .a_in  (a_h[i][j]),
        .b_in  (b_v[i][j]),
        .a_out (a_nxt),
        .b_out (b_nxt),
        .acc   (acc[i][j])
      );

      if (j < COLS - 1) begin : g_a_pass
        assign a_h[i][j+1] = a_nxt;
      end else begin : g_a_edge
        assign a_unused[i] = a_nxt;
      end

      if (i < ROWS - 1) begin : g_b_pass
        assign b_v[i+1][j] = b_nxt;
      end else begin : g_b_edge
        assign b_unused[j] = b_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      drain_cnt <= '0;
      row       <= '0;
      sgn       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sgn       <= cfg_signed;
            drain_cnt <= '0;
            busy      <= 1'b1;
            state     <= in_last ? ST_DRAIN : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept && in_last) begin
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end
        end
        // Long enough for the last beat to reach the far-corner PE.
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            row       <= '0;
            out_valid <= 1'b1;
            state     <= ST_OUT;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (row == ROW_LAST) begin
              row       <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              row <= row + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    out_row = '0;
    if (out_valid) begin
      for (int j = 0; j < COLS; j++) out_row[j*ACC_W +: ACC_W] = acc[row][j];
    end
  end

endmodule

// File: tb/tb_systolic_mm_array.sv
// Bench for systolic_mm_array: a 4x4/48-bit instance and a 2x3/32-bit instance,
// checked against a plain-arithmetic matrix product kept in the bench.
module tb_systolic_mm_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cfg_signed;
  logic        in_valid;
  logic        in_last;
  logic        out_ready;
  logic [63:0] a_vec;
  logic [63:0] b_vec;
  logic        sel;

  logic         in_ready_m, out_valid_m, busy_m;
  logic [191:0] out_row_m;
  logic [1:0]   out_idx_m;
  logic         in_ready_a, out_valid_a, busy_a;
  logic [95:0]  out_row_a;
  logic [0:0]   out_idx_a;

  systolic_mm_array #(.ROWS(4), .COLS(4), .DATA_W(16), .ACC_W(48)) u_main (
    .clk(clk), .rst_n(rst_n), .cfg_signed(cfg_signed),
    .in_valid(in_valid & ~sel), .in_ready(in_ready_m), .in_last(in_last),
    .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_row(out_row_m),
    .out_idx(out_idx_m), .busy(busy_m)
  );

  systolic_mm_array #(.ROWS(2), .COLS(3), .DATA_W(16), .ACC_W(32)) u_alt (
    .clk(clk), .rst_n(rst_n), .cfg_signed(cfg_signed),
    .in_valid(in_valid & sel), .in_ready(in_ready_a), .in_last(in_last),
    .a_vec(a_vec[31:0]), .b_vec(b_vec[47:0]),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_row(out_row_a),
    .out_idx(out_idx_a), .busy(busy_a)
  );

  // Observation view of whichever instance is selected, lanes widened to 48 bits.
  logic                obs_in_ready, obs_valid, obs_busy;
  int                  obs_idx;
  logic [3:0][47:0]    obs_row;
  always_comb begin
    obs_row = '0;
    if (sel) begin
      obs_in_ready = in_ready_a;
      obs_valid    = out_valid_a;
      obs_busy     = busy_a;
      obs_idx      = int'(out_idx_a);
      for (int j = 0; j < 3; j++) obs_row[j] = {16'h0, out_row_a[j*32 +: 32]};
    end else begin
      obs_in_ready = in_ready_m;
      obs_valid    = out_valid_m;
      obs_busy     = busy_m;
      obs_idx      = int'(out_idx_m);
      for (int j = 0; j < 4; j++) obs_row[j] = out_row_m[j*48 +: 48];
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  int cyc_cnt  = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Current geometry of the selected instance.
  int R = 4, C = 4, AW = 48;

  logic [15:0] ma [4][16];
  logic [15:0] mb [16][4];
  logic [191:0] exp_q[$];
  int           exp_idx_q[$];

  bit rnd_rdy  = 1'b0;
  bit lat_mode = 1'b0;
  int lat_k    = 0;
  int t0       = 0;

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic longint ext(input logic [15:0] v, input bit s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  // C[i][j] = sum_k A[i][k]*B[k][j], reduced modulo 2^AW.
  function automatic logic [47:0] model_c(input int i, input int j, input int k_n, input bit s);
    longint     sum = 0;
    logic [63:0] u;
    for (int k = 0; k < k_n; k++) sum += ext(ma[i][k], s) * ext(mb[k][j], s);
    u = sum;
    u = u & ((64'd1 << AW) - 64'd1);
    return u[47:0];
  endfunction

  task automatic push_model(input int k_n, input bit s);
    logic [3:0][47:0] v;
    for (int i = 0; i < R; i++) begin
      v = '0;
      for (int j = 0; j < C; j++) v[j] = model_c(i, j, k_n, s);
      exp_q.push_back(v);
      exp_idx_q.push_back(i);
    end
  endtask

  task automatic fill_random(input int k_n);
    for (int k = 0; k < k_n; k++) begin
      for (int i = 0; i < 4; i++) ma[i][k] = 16'($urandom);
      for (int j = 0; j < 4; j++) mb[k][j] = 16'($urandom);
    end
  endtask

  task automatic send_tile(input int k_n, input bit s, input bit bubbles, input bit push);
    int k = 0, cyc = 0, stall = 0;
    if (push) push_model(k_n, s);
    while (k < k_n) begin
      @(posedge clk); #1;
      if (bubbles && (cyc % 3 == 2)) begin
        in_valid   = 1'b0;
        in_last    = 1'b0;
        a_vec      = {$urandom, $urandom};
        b_vec      = {$urandom, $urandom};
        cfg_signed = 1'($urandom);
      end else begin
        in_valid   = 1'b1;
        in_last    = (k == k_n - 1);
        cfg_signed = (k == 0) ? s : 1'($urandom);
        a_vec      = '0;
        b_vec      = '0;
        for (int i = 0; i < R; i++) a_vec[i*16 +: 16] = ma[i][k];
        for (int j = 0; j < C; j++) b_vec[j*16 +: 16] = mb[k][j];
      end
      cyc++;
      if (in_valid && obs_in_ready) begin
        if (k == 0) t0 = cyc_cnt;
        k++;
      end else if (in_valid && ++stall > 200) begin
        check("in_ready_timeout", 192'(k), 192'(k_n));
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    check("drain_ctl", {obs_in_ready, obs_busy}, 2'b01);
    while (exp_q.size() > 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("rows_left", 192'(exp_q.size()), 192'd0);
  endtask

  // Single compare process: every cycle with out_valid is checked against the model.
  logic [3:0][47:0] prev_row;
  int               prev_idx;
  bit               prev_valid = 1'b0, prev_ready = 1'b0;
  always @(negedge clk) begin
    if (obs_valid) begin
      if (prev_valid && !prev_ready) begin
        check("hold_row", obs_row, prev_row);
        check("hold_idx", 192'(obs_idx), 192'(prev_idx));
      end
      if (exp_q.size() == 0) begin
        check("unexpected_row", 192'(obs_idx), 192'hDEAD);
      end else begin
        check("row", obs_row, exp_q[0]);
        check("idx", 192'(obs_idx), 192'(exp_idx_q[0]));
        check("out_ctl", {obs_in_ready, obs_busy}, 2'b01);
        if (lat_mode && !prev_valid)
          check("first_valid_cycle", 192'(cyc_cnt - t0), 192'(lat_k + R + C - 1));
        if (out_ready) begin
          if (lat_mode && exp_idx_q[0] == R - 1)
            check("last_row_cycle", 192'(cyc_cnt - t0), 192'(lat_k + R + C - 2 + R));
          void'(exp_q.pop_front());
          void'(exp_idx_q.pop_front());
        end
      end
    end
    prev_valid = obs_valid;
    prev_ready = out_ready;
    prev_row   = obs_row;
    prev_idx   = obs_idx;
  end

  always @(posedge clk) begin
    #1;
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cfg_signed = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; a_vec = '0; b_vec = '0; sel = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {in_ready_m, in_ready_a}, 2'b00);
    check("rst_outs_m", {out_valid_m, busy_m, out_idx_m, out_row_m}, '0);
    check("rst_outs_a", {out_valid_a, busy_a, out_idx_a, out_row_a}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", {in_ready_m, in_ready_a}, 2'b11);
    check("idle_busy", {busy_m, busy_a, out_valid_m, out_valid_a}, 4'b0000);

    // Outer product, unsigned, K=1, with latency pinned.
    for (int i = 0; i < 4; i++) begin ma[i][0] = 16'(i + 1); mb[0][i] = 16'(i + 5); end
    check("pin_outer_row3", {model_c(3, 3, 1, 0), model_c(3, 2, 1, 0), model_c(3, 1, 1, 0), model_c(3, 0, 1, 0)},
          {48'd32, 48'd28, 48'd24, 48'd20});
    lat_mode = 1'b1; lat_k = 1;
    send_tile(1, 1'b0, 1'b0, 1'b1);
    wait_drain();
    lat_mode = 1'b0;

    // Signed identity times all -3.
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++) begin ma[i][k] = (i == k) ? 16'd1 : 16'd0; mb[k][i] = 16'hFFFD; end
    check("pin_signed_ident", {model_c(0, 0, 4, 1), model_c(2, 1, 4, 1)}, {48'hFFFF_FFFF_FFFD, 48'hFFFF_FFFF_FFFD});
    send_tile(4, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // Random K=8 with input bubbles and output backpressure.
    rnd_rdy = 1'b1;
    for (int t = 0; t < 3; t++) begin
      fill_random(8);
      send_tile(8, 1'($urandom), 1'b1, 1'b1);
      wait_drain();
    end
    rnd_rdy = 1'b0;

    // 2x3 array with a 32-bit accumulator: wrap-around.
    @(posedge clk); #1;
    sel = 1'b1; R = 2; C = 3; AW = 32;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) begin ma[i][k] = 16'hFFFF; mb[k][i] = 16'hFFFF; end
    check("pin_wrap", 192'(model_c(0, 0, 2, 0)), 192'h0000_FFFC_0002);
    lat_mode = 1'b1; lat_k = 2;
    send_tile(2, 1'b0, 1'b0, 1'b1);
    wait_drain();
    lat_mode = 1'b0;

    // 2x3 signed random K=3 under backpressure.
    rnd_rdy = 1'b1;
    for (int t = 0; t < 3; t++) begin
      fill_random(3);
      send_tile(3, 1'b1, 1'b0, 1'b1);
      wait_drain();
    end
    rnd_rdy = 1'b0;

    // Reset during DRAIN discards the tile; the next tile starts from clean sums.
    @(posedge clk); #1;
    sel = 1'b0; R = 4; C = 4; AW = 48;
    fill_random(5);
    send_tile(5, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_cycle", {in_ready_m, busy_m}, 2'b01);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst", {in_ready_m, busy_m, out_valid_m}, 3'b100);
    for (int i = 0; i < 4; i++) begin ma[i][0] = 16'd1; mb[0][i] = 16'd1; end
    check("pin_ones", 192'(model_c(1, 2, 1, 0)), 192'd1);
    send_tile(1, 1'b0, 1'b0, 1'b1);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
